pll_rst_seq: RTL and testbench

Power-up and lock-supervision controller for the on-chip PLL and the clock-divider chain it feeds. It enables the PLL, pulses its reset, and waits for a stable lock, retrying on timeout. It then gates the PLL outputs on and releases the downstream divider resets one stage at a time. On loss of lock it tears the chain down and relocks. After too many consecutive failed lock attempts it parks in a fault state.

---
 rtl/pll_rst_seq_pkg.sv | 16 +
 rtl/pll_rst_seq_sync2.sv | 21 ++
 rtl/pll_rst_seq.sv | 190 +++++++++++++++++++
 tb/tb_pll_rst_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_seq_pkg.sv
// Shared types for the PLL power-up / lock-supervision sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STAGE     = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam int RETRY_W = 4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

endpackage

// File: rtl/pll_rst_seq_sync2.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the system clock domain.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL bring-up sequencer: reset pulse, lock qualification with retry, staged divider
// reset release, loss-of-lock teardown and a sticky fault after repeated failures.
module pll_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE   = 4,
    parameter int LOCK_WAIT   = 4096,
    parameter int LOCK_STABLE = 64,
    parameter int STAGE_GAP   = 256,
    parameter int NSTAGE      = 3,
    parameter int MAX_RETRY   = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               LOCK,
    output logic               PLL_EN,
    output logic               PLL_RESETN,
    output logic               CLKOUT_EN,
    output logic [NSTAGE-1:0]  STAGE_NRST,
    output logic               READY,
    output logic               FAULT,
    output logic [RETRY_W-1:0] RETRY_CNT
);

    // The pulse and timeout phases never overlap, so they share one counter.
    localparam int CNT_MAX = (LOCK_WAIT > RST_PULSE) ? LOCK_WAIT : RST_PULSE;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int STB_W   = $clog2(LOCK_STABLE) + 1;
    localparam int GAP_W   = $clog2(STAGE_GAP) + 1;
    localparam int FAIL_W  = $clog2(MAX_RETRY) + 1;

    localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0]  WAIT_T     = CNT_W'(LOCK_WAIT);
    localparam logic [STB_W-1:0]  STABLE_T   = STB_W'(LOCK_STABLE);
    localparam logic [GAP_W-1:0]  GAP_T      = GAP_W'(STAGE_GAP);
    localparam logic [FAIL_W-1:0] FAIL_T     = FAIL_W'(MAX_RETRY);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [STB_W-1:0]    stable, stable_nxt;
    logic [GAP_W-1:0]    gap, gap_nxt;
    logic [FAIL_W-1:0]   fail_cnt, fail_nxt;
    logic [NSTAGE-1:0]   stage_nxt;
    logic                retry_inc;
    logic                lock_s;

    logic                en_d, rstn_d, ck_d, ready_d, fault_d;
    logic [NSTAGE-1:0]   nrst_d;

    sync2 u_lock_sync (
        .clk (CLK),
        .rst (RST),
        .d   (LOCK),
        .q   (lock_s)
    );

    // State, counters and every output are registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_OFF;
            cnt        <= '0;
            stable     <= '0;
            gap        <= '0;
            fail_cnt   <= '0;
            RETRY_CNT  <= '0;
            PLL_EN     <= 1'b0;
            PLL_RESETN <= 1'b0;
            CLKOUT_EN  <= 1'b0;
            STAGE_NRST <= '0;
            READY      <= 1'b0;
            FAULT      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            stable     <= stable_nxt;
            gap        <= gap_nxt;
            fail_cnt   <= fail_nxt;
            if (retry_inc && RETRY_CNT != RETRY_MAX)
                RETRY_CNT <= RETRY_CNT + 1'b1;
            PLL_EN     <= en_d;
            PLL_RESETN <= rstn_d;
            CLKOUT_EN  <= ck_d;
            STAGE_NRST <= nrst_d;
            READY      <= ready_d;
            FAULT      <= fault_d;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stable_nxt = stable;
        gap_nxt    = gap;
        fail_nxt   = fail_cnt;
        stage_nxt  = '0;
        retry_inc  = 1'b0;
        case (state)
            ST_OFF: begin
                state_nxt = ST_PLL_RST;
                cnt_nxt   = '0;
            end
            ST_PLL_RST: begin
                if (cnt == PULSE_LAST) begin
                    state_nxt  = ST_WAIT_LOCK;
                    cnt_nxt    = '0;
                    stable_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                cnt_nxt    = cnt + 1'b1;
                stable_nxt = lock_s ? stable + 1'b1 : '0;
                // Lock qualification is checked first so it wins a tie with the timeout.
                if (stable_nxt == STABLE_T) begin
                    state_nxt = ST_STAGE;
                    gap_nxt   = '0;
                end else if (cnt_nxt == WAIT_T) begin
                    retry_inc = 1'b1;
                    fail_nxt  = fail_cnt + 1'b1;
                    cnt_nxt   = '0;
                    stable_nxt = '0;
                    state_nxt = (fail_nxt == FAIL_T) ? ST_FAULT : ST_PLL_RST;
                end
            end
            ST_STAGE: begin
                if (!lock_s) begin
                    state_nxt = ST_PLL_RST;
                    cnt_nxt   = '0;
                    retry_inc = 1'b1;
                end else begin
                    gap_nxt   = gap + 1'b1;
                    stage_nxt = STAGE_NRST;
                    if (gap_nxt == GAP_T) begin
                        gap_nxt   = '0;
                        stage_nxt = NSTAGE'({STAGE_NRST, 1'b1});
                        if (stage_nxt[NSTAGE-1]) begin
                            state_nxt = ST_RUN;
                            fail_nxt  = '0;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt = ST_PLL_RST;
                    cnt_nxt   = '0;
                    retry_inc = 1'b1;
                end else begin
                    stage_nxt = '1;
                end
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_OFF;
        endcase
    end

    // Output values are decoded from the next state so they land in flops with the state.
    always_comb begin
        en_d    = 1'b0;
        rstn_d  = 1'b0;
        ck_d    = 1'b0;
        ready_d = 1'b0;
        fault_d = 1'b0;
        nrst_d  = '0;
        case (state_nxt)
            ST_PLL_RST: en_d = 1'b1;
            ST_WAIT_LOCK: begin
                en_d   = 1'b1;
                rstn_d = 1'b1;
            end
            ST_STAGE: begin
                en_d   = 1'b1;
                rstn_d = 1'b1;
                ck_d   = 1'b1;
                nrst_d = stage_nxt;
            end
            ST_RUN: begin
                en_d    = 1'b1;
                rstn_d  = 1'b1;
                ck_d    = 1'b1;
                nrst_d  = '1;
                ready_d = 1'b1;
            end
            ST_FAULT: fault_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Scoreboard bench for pll_rst_seq: directed LOCK waveforms push time-stamped expected output words.
module tb_pll_rst_seq;

    localparam int NSTAGE = 3;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              LOCK = 1'b0;
    logic              PLL_EN, PLL_RESETN, CLKOUT_EN, READY, FAULT;
    logic [NSTAGE-1:0] STAGE_NRST;
    logic [3:0]        RETRY_CNT;

    pll_rst_seq #(
        .RST_PULSE   (4),
        .LOCK_WAIT   (100),
        .LOCK_STABLE (8),
        .STAGE_GAP   (16),
        .NSTAGE      (NSTAGE),
        .MAX_RETRY   (3)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .LOCK       (LOCK),
        .PLL_EN     (PLL_EN),
        .PLL_RESETN (PLL_RESETN),
        .CLKOUT_EN  (CLKOUT_EN),
        .STAGE_NRST (STAGE_NRST),
        .READY      (READY),
        .FAULT      (FAULT),
        .RETRY_CNT  (RETRY_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [11:0] val;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    int          b = 0;
    logic [11:0] cur_o, prev_o = '0;

    // Output word: {FAULT, READY, RETRY_CNT, STAGE_NRST, CLKOUT_EN, PLL_RESETN, PLL_EN}
    function automatic logic [11:0] ov(input logic f, input logic r, input int rc,
                                       input logic [2:0] ns, input logic ck,
                                       input logic rn, input logic en);
        return {f, r, 4'(rc), ns, ck, rn, en};
    endfunction

    task automatic expect_at(input int c, input logic [11:0] v, input string nm);
        q.push_back('{c, v, nm});
    endtask

    // Monitor: every scheduled word is compared at its cycle; any other output change is an error.
    always @(negedge CLK) begin
        cur_o = {FAULT, READY, RETRY_CNT, STAGE_NRST, CLKOUT_EN, PLL_RESETN, PLL_EN};
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || cur_o !== e.val) begin
                errors++;
                $display("FAIL %s at cyc %0d (due %0d): got %b want %b", e.name, cyc, e.cyc, cur_o, e.val);
            end
        end else if (cur_o !== prev_o) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change at cyc %0d: got %b was %b", cyc, cur_o, prev_o);
        end
        prev_o = cur_o;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    // Assert RST for two edges; b becomes the last cycle with RST sampled high.
    task automatic start_rst();
        int r0;
        RST  = 1'b1;
        LOCK = 1'b0;
        r0   = cyc;
        expect_at(r0 + 1, '0, "reset");
        tick();
        tick();
        b   = cyc;
        RST = 1'b0;
    endtask

    task automatic exp_pulse(input int c, input int rc);
        expect_at(c,     ov(0, 0, rc, 3'b000, 0, 0, 1), $sformatf("pll_rst_rc%0d", rc));
        expect_at(c + 4, ov(0, 0, rc, 3'b000, 0, 1, 1), $sformatf("resetn_rel_rc%0d", rc));
    endtask

    task automatic exp_ramp(input int ck_c, input int rc, input int n);
        expect_at(ck_c, ov(0, 0, rc, 3'b000, 1, 1, 1), "clkout_en");
        for (int i = 1; i <= n; i++)
            expect_at(ck_c + 16 * i, ov(0, i == 3, rc, 3'((1 << i) - 1), 1, 1, 1),
                      $sformatf("stage%0d", i - 1));
    endtask

    initial begin
        // Clean bring-up, then loss of lock in RUN and full relock.
        start_rst();
        exp_pulse(b + 1, 0);
        exp_ramp(b + 30, 0, 3);
        wait_to(b + 20); LOCK = 1'b1;
        wait_to(b + 85); LOCK = 1'b0;
        exp_pulse(b + 88, 1);
        exp_ramp(b + 110, 1, 3);
        wait_to(b + 100); LOCK = 1'b1;
        wait_to(b + 165);

        // RST while STAGE_NRST=011, then bring-up repeats with the same timing.
        start_rst();
        exp_pulse(b + 1, 0);
        exp_ramp(b + 30, 0, 2);
        wait_to(b + 20); LOCK = 1'b1;
        wait_to(b + 65);
        start_rst();
        exp_pulse(b + 1, 0);
        exp_ramp(b + 30, 0, 3);
        wait_to(b + 20); LOCK = 1'b1;
        wait_to(b + 85);

        // Lock chatter in WAIT_LOCK, then loss of lock during STAGE.
        start_rst();
        exp_pulse(b + 1, 0);
        exp_ramp(b + 38, 0, 1);
        exp_pulse(b + 63, 1);
        wait_to(b + 20); LOCK = 1'b1;
        wait_to(b + 27); LOCK = 1'b0;
        tick();          LOCK = 1'b1;
        wait_to(b + 60); LOCK = 1'b0;
        wait_to(b + 75);

        // Lock qualifies on the same cycle the timeout expires: lock wins.
        start_rst();
        exp_pulse(b + 1, 0);
        exp_ramp(b + 105, 0, 1);
        wait_to(b + 95); LOCK = 1'b1;
        wait_to(b + 125);

        // LOCK never asserts: three pulses, then sticky FAULT even if LOCK appears.
        start_rst();
        exp_pulse(b + 1, 0);
        exp_pulse(b + 105, 1);
        exp_pulse(b + 209, 2);
        expect_at(b + 313, ov(1, 0, 3, 3'b000, 0, 0, 0), "fault");
        wait_to(b + 330); LOCK = 1'b1;
        wait_to(b + 360);

        // Two timeouts, lock on the third attempt; RUN clears fail_cnt so a later timeout retries.
        start_rst();
        exp_pulse(b + 1, 0);
        exp_pulse(b + 105, 1);
        exp_pulse(b + 209, 2);
        exp_ramp(b + 260, 2, 3);
        exp_pulse(b + 318, 3);
        exp_pulse(b + 422, 4);
        wait_to(b + 250); LOCK = 1'b1;
        wait_to(b + 315); LOCK = 1'b0;
        wait_to(b + 430);

        tick();
        tick();
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never_checked: due cyc %0d want %b", e.name, e.cyc, e.val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
